// File: rtl/complex_operand_gather_if.sv
// complex_operand_gather_if: group-in / vector-out handshake bundle for complex_operand_gather
// Signals are named from the gather block's point of view; slave = gather, master = its environment.
// Optional macro COMPLEX_GATHER_LAST_EN adds in_last_i.
interface complex_operand_gather_if #(
    parameter int SIZE = 16,
    parameter int WORD = 64
);
    logic [4*WORD-1:0]      in_data_i;
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [SIZE*4*WORD-1:0] operands_o;
    logic                   out_valid_o;
    logic                   out_ready_i;
`ifdef COMPLEX_GATHER_LAST_EN
    logic                   in_last_i;
    modport slave (input in_data_i, in_valid_i, in_last_i, out_ready_i,
                   output in_ready_o, operands_o, out_valid_o);
    modport master (output in_data_i, in_valid_i, in_last_i, out_ready_i,
                    input in_ready_o, operands_o, out_valid_o);
`else
    modport slave (input in_data_i, in_valid_i, out_ready_i,
                   output in_ready_o, operands_o, out_valid_o);
    modport master (output in_data_i, in_valid_i, out_ready_i,
                    input in_ready_o, operands_o, out_valid_o);
`endif
endinterface

// File: rtl/complex_operand_gather.sv
// complex_operand_gather: ping-pong gatherer of SIZE complex operand groups into one flat vector
// Ports: clk_i, rst_i (sync, active-high), flush_i (sync abort), bus (slave: in_data/in_valid/in_ready
// group input, operands/out_valid/out_ready vector output), fill_idx_o (next fill slot), busy_o.
// Optional macro COMPLEX_GATHER_LAST_EN: in_last_i closes a vector early, zeroing unfilled slots.
module complex_operand_gather #(
    parameter int SIZE = 16,
    parameter int WORD = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    complex_operand_gather_if.slave   bus,
    output logic [$clog2(SIZE)-1:0]   fill_idx_o,
    output logic                      busy_o
);
    localparam int IW = $clog2(SIZE);
    localparam int GW = 4 * WORD;
    localparam int VW = SIZE * GW;

    logic [VW-1:0] bank_q [2];
    logic [VW-1:0] bank_d [2];
    logic [1:0]    full_q, full_d;
    logic          wr_q, wr_d, rd_q, rd_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          accept, drain, close;

    assign bus.in_ready_o  = ~full_q[wr_q];
    assign bus.out_valid_o = full_q[rd_q];
    assign bus.operands_o  = bank_q[rd_q];
    assign fill_idx_o      = idx_q;
    assign busy_o          = |full_q | (idx_q != '0);
    assign accept          = bus.in_valid_i & bus.in_ready_o;
    assign drain           = bus.out_valid_o & bus.out_ready_i;
`ifdef COMPLEX_GATHER_LAST_EN
    assign close = (idx_q == IW'(SIZE - 1)) | bus.in_last_i;
`else
    assign close = idx_q == IW'(SIZE - 1);
`endif

    // Fill and drain can complete in the same cycle: an accept needs the fill
    // bank empty, a drain needs the read bank full, so they never collide.
    always_comb begin
        bank_d = bank_q;
        full_d = full_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        idx_d  = idx_q;
        if (flush_i) begin
            full_d = '0;
            wr_d   = 1'b0;
            rd_d   = 1'b0;
            idx_d  = '0;
        end else begin
            if (drain) begin
                full_d[rd_q] = 1'b0;
                rd_d         = ~rd_q;
            end
            if (accept) begin
                bank_d[wr_q][int'(idx_q)*GW +: GW] = bus.in_data_i;
`ifdef COMPLEX_GATHER_LAST_EN
                for (int s = 0; s < SIZE; s++)
                    if (bus.in_last_i && s > int'(idx_q)) bank_d[wr_q][s*GW +: GW] = '0;
`endif
                if (close) begin
                    full_d[wr_q] = 1'b1;
                    wr_d         = ~wr_q;
                    idx_d        = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bank_q <= '{default: '0};
            full_q <= '0;
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            idx_q  <= '0;
        end else begin
            bank_q <= bank_d;
            full_q <= full_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            idx_q  <= idx_d;
        end
    end
endmodule

// File: tb/tb_complex_operand_gather.sv
// tb_complex_operand_gather: directed self-checking bench for complex_operand_gather
module tb_complex_operand_gather;
    localparam int SIZE = 16;
    localparam int WORD = 64;
    localparam int GW   = 4 * WORD;
    localparam int VW   = SIZE * GW;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [3:0] fill_idx;
    logic       busy;
    int         pass_cnt = 0;
    int         total = 0;

    always #5 clk = ~clk;

    complex_operand_gather_if #(.SIZE(SIZE), .WORD(WORD)) bus ();

    complex_operand_gather #(.SIZE(SIZE), .WORD(WORD)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_i    (flush),
        .bus        (bus.slave),
        .fill_idx_o (fill_idx),
        .busy_o     (busy)
    );

    function automatic logic [GW-1:0] grp(input logic [63:0] base);
        return {base + 64'd3, base + 64'd2, base + 64'd1, base};
    endfunction

    function automatic logic [VW-1:0] seqv(input logic [63:0] base, input int ngroups);
        logic [VW-1:0] v = '0;
        for (int n = 0; n < ngroups * 4; n++) v[n*64 +: 64] = base + 64'(n);
        return v;
    endfunction

    function automatic int first_diff(input logic [VW-1:0] a, input logic [VW-1:0] b);
        for (int n = 0; n < SIZE * 4; n++) if (a[n*64 +: 64] !== b[n*64 +: 64]) return n;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = '0;
        bus.out_ready_i = 1'b0;
        flush           = 1'b0;
`ifdef COMPLEX_GATHER_LAST_EN
        bus.in_last_i   = 1'b0;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic beat(input logic [GW-1:0] d);
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = d;
        tick();
        bus.in_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = grp(64'd77);
        rst = 1'b1;
        tick();
        tick();
        bus.in_valid_i = 1'b0;
        rst = 1'b0;
        total++; if (bus.in_ready_o !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready_o); else pass_cnt++;
        total++; if (bus.out_valid_o !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid_o); else pass_cnt++;
        total++; if (bus.operands_o !== '0) $display("FAIL reset_operands word %0d nonzero", first_diff(bus.operands_o, '0)); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        total++; if (fill_idx !== 4'd0) $display("FAIL reset_fill_idx got %0d want 0", fill_idx); else pass_cnt++;
    endtask

    task automatic test_single_vector();
        logic [VW-1:0] exp_v = seqv(64'd0, 16);
        do_reset();
        for (int k = 0; k < 15; k++) beat(grp(64'(k * 4)));
        total++; if (bus.out_valid_o !== 1'b0) $display("FAIL single_early_valid got %b want 0", bus.out_valid_o); else pass_cnt++;
        total++; if (fill_idx !== 4'd15) $display("FAIL single_idx15 got %0d want 15", fill_idx); else pass_cnt++;
        beat(grp(64'd60));
        total++; if (bus.out_valid_o !== 1'b1) $display("FAIL single_valid got %b want 1", bus.out_valid_o); else pass_cnt++;
        total++; if (bus.operands_o !== exp_v)
            $display("FAIL single_data word %0d got %h want %h", first_diff(bus.operands_o, exp_v),
                     bus.operands_o[first_diff(bus.operands_o, exp_v)*64 +: 64], exp_v[first_diff(bus.operands_o, exp_v)*64 +: 64]);
        else pass_cnt++;
        total++; if (fill_idx !== 4'd0) $display("FAIL single_idx_wrap got %0d want 0", fill_idx); else pass_cnt++;
        total++; if (bus.in_ready_o !== 1'b1 || busy !== 1'b1) $display("FAIL single_ready_busy got %b%b want 11", bus.in_ready_o, busy); else pass_cnt++;
        for (int i = 0; i < 3; i++) tick();
        total++; if (bus.out_valid_o !== 1'b1 || bus.operands_o !== exp_v) $display("FAIL single_hold valid %b word %0d", bus.out_valid_o, first_diff(bus.operands_o, exp_v)); else pass_cnt++;
        bus.out_ready_i = 1'b1;
        tick();
        bus.out_ready_i = 1'b0;
        total++; if (bus.out_valid_o !== 1'b0 || busy !== 1'b0) $display("FAIL single_drain valid %b busy %b want 0 0", bus.out_valid_o, busy); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 0; k < 32; k++) beat(grp(64'(k * 4)));
        total++; if (bus.in_ready_o !== 1'b0) $display("FAIL bp_ready_low got %b want 0", bus.in_ready_o); else pass_cnt++;
        total++; if (bus.operands_o !== seqv(64'd0, 16) || bus.out_valid_o !== 1'b1) $display("FAIL bp_vec0 valid %b word %0d", bus.out_valid_o, first_diff(bus.operands_o, seqv(64'd0, 16))); else pass_cnt++;
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = grp(64'd128);
        for (int i = 0; i < 3; i++) tick();
        total++; if (bus.in_ready_o !== 1'b0 || fill_idx !== 4'd0) $display("FAIL bp_stall ready %b idx %0d want 0 0", bus.in_ready_o, fill_idx); else pass_cnt++;
        bus.out_ready_i = 1'b1;
        tick();
        bus.out_ready_i = 1'b0;
        total++; if (bus.in_ready_o !== 1'b1) $display("FAIL bp_ready_back got %b want 1", bus.in_ready_o); else pass_cnt++;
        total++; if (fill_idx !== 4'd0) $display("FAIL bp_no_bypass idx got %0d want 0", fill_idx); else pass_cnt++;
        total++; if (bus.out_valid_o !== 1'b1 || bus.operands_o !== seqv(64'd64, 16)) $display("FAIL bp_vec1 valid %b word %0d", bus.out_valid_o, first_diff(bus.operands_o, seqv(64'd64, 16))); else pass_cnt++;
        for (int k = 32; k < 40; k++) beat(grp(64'(k * 4)));
        total++; if (fill_idx !== 4'd8 || bus.in_ready_o !== 1'b1) $display("FAIL bp_resume idx %0d ready %b want 8 1", fill_idx, bus.in_ready_o); else pass_cnt++;
    endtask

    task automatic test_streaming();
        int nvec = 0;
        int cyc [4];
        logic ready_bad = 1'b0;
        logic data_bad = 1'b0;
        do_reset();
        bus.out_ready_i = 1'b1;
        for (int c = 1; c <= 66; c++) begin
            if (bus.out_valid_o) begin
                if (nvec < 4) begin
                    cyc[nvec] = c;
                    if (bus.operands_o !== seqv(64'(nvec * 64), 16)) data_bad = 1'b1;
                end
                nvec++;
            end
            if (c <= 64) begin
                if (!bus.in_ready_o) ready_bad = 1'b1;
                bus.in_valid_i = 1'b1;
                bus.in_data_i  = grp(64'((c - 1) * 4));
            end else begin
                bus.in_valid_i = 1'b0;
            end
            tick();
        end
        bus.out_ready_i = 1'b0;
        total++; if (nvec !== 4) $display("FAIL stream_count got %0d want 4", nvec); else pass_cnt++;
        total++; if (nvec >= 4 && (cyc[0] !== 17 || cyc[1] !== 33 || cyc[2] !== 49 || cyc[3] !== 65))
            $display("FAIL stream_timing got %0d %0d %0d %0d want 17 33 49 65", cyc[0], cyc[1], cyc[2], cyc[3]);
        else if (nvec < 4) $display("FAIL stream_timing only %0d vectors want 4", nvec);
        else pass_cnt++;
        total++; if (ready_bad !== 1'b0) $display("FAIL stream_ready got low want always high"); else pass_cnt++;
        total++; if (data_bad !== 1'b0) $display("FAIL stream_data got wrong vector contents want sequential"); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL stream_idle_busy got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_flush();
        logic [VW-1:0] exp_v;
        for (int n = 0; n < SIZE * 4; n++) exp_v[n*64 +: 64] = 64'hA5;
        do_reset();
        for (int k = 0; k < 7; k++) beat(grp(64'(1000 + k * 4)));
        total++; if (fill_idx !== 4'd7 || busy !== 1'b1) $display("FAIL flush_pre idx %0d busy %b want 7 1", fill_idx, busy); else pass_cnt++;
        flush = 1'b1;
        beat(grp(64'd9999));
        flush = 1'b0;
        total++; if (fill_idx !== 4'd0 || busy !== 1'b0 || bus.in_ready_o !== 1'b1) $display("FAIL flush_clear idx %0d busy %b ready %b want 0 0 1", fill_idx, busy, bus.in_ready_o); else pass_cnt++;
        for (int k = 0; k < 16; k++) beat({4{64'hA5}});
        total++; if (bus.out_valid_o !== 1'b1 || bus.operands_o !== exp_v) $display("FAIL flush_vec valid %b word %0d", bus.out_valid_o, first_diff(bus.operands_o, exp_v)); else pass_cnt++;
    endtask

`ifdef COMPLEX_GATHER_LAST_EN
    task automatic test_last();
        do_reset();
        bus.out_ready_i = 1'b1;
        for (int k = 0; k < 32; k++) beat(grp(64'(k * 4)));
        tick();
        bus.out_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) beat(grp(64'(5000 + k * 4)));
        bus.in_last_i = 1'b1;
        beat(grp(64'd5016));
        bus.in_last_i = 1'b0;
        total++; if (bus.out_valid_o !== 1'b1 || fill_idx !== 4'd0) $display("FAIL last_close valid %b idx %0d want 1 0", bus.out_valid_o, fill_idx); else pass_cnt++;
        total++; if (bus.operands_o !== seqv(64'd5000, 5)) $display("FAIL last_data word %0d", first_diff(bus.operands_o, seqv(64'd5000, 5))); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_single_vector();
        test_backpressure();
        test_streaming();
        test_flush();
`ifdef COMPLEX_GATHER_LAST_EN
        test_last();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
